pagerank_graph_loader: RTL and testbench
========================================

Name: pagerank_graph_loader

Overview:
Writer-side front end for pagerank_DMP_serial. It accepts a serial word stream describing the graph and fills the per-thread source_id, out_degree and dest_id arrays that the engine reads. It then raises pagerank_enable and holds it until the engine reports pagerank_complete. It sits between the host/DMA stream and the serial pagerank engine.

Parameters:
NUM_HW_THREADS, 11, number of engine threads; first dimension of the graph arrays.
NODES_IN_PARTITION, 1, nodes per thread; second dimension.
NODES_IN_GRAPH, 11, total nodes; must equal NUM_HW_THREADS*NODES_IN_PARTITION.
STREAM_SIZE, 4, maximum out-degree; third dimension of dest_id.

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous active-low reset, sampled on the rising edge of clock
start  in  1  one-cycle pulse; begins a load, ignored unless in IDLE or DONE
in_data  in  32  stream word: out-degree header or destination id
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts a word this cycle
in_last  in  1  marks the final word of the graph
source_id  out  32 x [NUM_HW_THREADS][NODES_IN_PARTITION]  node id per slot
out_degree  out  32 x [NUM_HW_THREADS][NODES_IN_PARTITION]  out-degree per slot
dest_id  out  32 x [NUM_HW_THREADS][NODES_IN_PARTITION][STREAM_SIZE]  destinations; unused entries are 0
pagerank_enable  out  1  run request to the engine
pagerank_complete  in  1  engine finished
busy  out  1  state is not IDLE, DONE or ERROR
done  out  1  level; high in DONE
error  out  1  level; high in ERROR
error_code  out  2  1 = degree > STREAM_SIZE, 2 = dest >= NODES_IN_GRAPH, 3 = in_last misplaced

Behaviour:
- Handshake: a word transfers on a rising edge where in_valid and in_ready are both 1. in_ready is a registered output, high only in HEADER and DEST.
- Stream format, per node n in order 0..NODES_IN_GRAPH-1:
  - one header word carrying the out-degree d;
  - then d destination-id words.
- Node n maps to slot [n / NODES_IN_PARTITION][n % NODES_IN_PARTITION]. source_id of that slot is written with n.
- Reset, and start from IDLE or DONE, both clear:
  - all arrays, pagerank_enable, done, error, error_code, the node counter and the edge counter;
  - all outputs reset to 0.
- States:
  - IDLE: start moves to HEADER.
  - HEADER: on an accepted word, if d > STREAM_SIZE go to ERROR(1); otherwise write out_degree. If d = 0, advance the node and stay in HEADER (or go to ARM if it was the last node); otherwise go to DEST.
  - DEST: on an accepted word, if the value >= NODES_IN_GRAPH go to ERROR(2); otherwise write dest_id[slot][edge]. After the d-th edge, advance the node and return to HEADER, or go to ARM after the last node.
  - ARM: one cycle, pagerank_enable is set to 1, then go to RUN.
  - RUN: hold pagerank_enable = 1. When pagerank_complete = 1, drop pagerank_enable the next cycle and go to DONE.
  - DONE: arrays are held stable. start restarts the load.
  - ERROR: sticky; only reset_n exits it.
- in_last rules:
  - in_last is required on exactly the final word of node NODES_IN_GRAPH-1. Missing or early in_last goes to ERROR(3).
  - Priority when one word has several faults: error codes 1 and 2 take precedence over 3.
- start outside IDLE or DONE is ignored. in_valid outside HEADER and DEST is ignored.
- Arrays are written only through the stream and are stable whenever pagerank_enable = 1.
- Throughput and latency:
  - one word per cycle;
  - pagerank_enable rises 2 cycles after the final word is accepted (ARM, then RUN);
  - done rises 1 cycle after pagerank_complete is sampled high in RUN.
- Reset mid-load or mid-run: all state and arrays clear on the next edge, and pagerank_enable drops.

Decomposition:
- Package pagerank_pkg holds:
  - the state enum loader_state_t;
  - localparams ERR_DEGREE = 1, ERR_DEST = 2, ERR_LAST = 3;
  - the default graph-size constants shared with the engine.
- One sub-module, pagerank_slot_index: combinational node-to-(thread, slot) mapping, shared with a future result reader.

Test Plan:
- 11-node graph sent with in_valid continuously high:
  - headers 4, 4, 1, 1, 2, 2, 2, 2, 0, 0, 0; node 0 dests 2,3,4,5; node 1 dests 2,3,6,7; node 2 dest 10; node 3 dest 9; node 4 dests 8,9; node 5 dests 8,10; node 6 dests 8,9; node 7 dests 8,10;
  - 29 words are accepted in 29 cycles;
  - dest_id[2][0] = {10,0,0,0}, out_degree[8][0] = 0, source_id[k][0] = k;
  - pagerank_enable rises 2 cycles after the 29th word.
- Same graph with in_valid toggled randomly: identical arrays result, and no word is accepted while in_ready = 0.
- Header value 5 on node 0: error = 1 and error_code = 1 next cycle, in_ready = 0, pagerank_enable stays 0.
- Destination value 11 on node 4: error_code = 2.
- in_last asserted on word 10, or absent on word 29: error_code = 3.
- pagerank_complete pulsed 7 cycles into RUN: pagerank_enable drops next cycle and done = 1. A following start clears the arrays and reloads.
- reset_n low for one cycle during DEST: all outputs 0 and state IDLE. A subsequent full load succeeds.

Source files
------------

// File: rtl/pagerank_pkg.sv
// Shared types and constants for the pagerank graph loader and engine.
package pagerank_pkg;

    // Default graph geometry shared with the serial pagerank engine.
    localparam int NUM_HW_THREADS_DEF     = 11;
    localparam int NODES_IN_PARTITION_DEF = 1;
    localparam int NODES_IN_GRAPH_DEF     = 11;
    localparam int STREAM_SIZE_DEF        = 4;

    // Error codes reported on error_code.
    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_DEGREE = 2'd1;
    localparam logic [1:0] ERR_DEST   = 2'd2;
    localparam logic [1:0] ERR_LAST   = 2'd3;

    // Loader control states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_DEST   = 3'd2,
        ST_ARM    = 3'd3,
        ST_RUN    = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } loader_state_t;

endpackage

// File: rtl/pagerank_slot_index.sv
// Maps a flat node number onto its (thread, slot) position in the graph arrays.
module pagerank_slot_index
    import pagerank_pkg::*;
#(
    parameter int NODES_IN_PARTITION = NODES_IN_PARTITION_DEF,
    parameter int IDX_W              = 4
) (
    input  logic [IDX_W-1:0] node_i,
    output logic [IDX_W-1:0] thread_o,
    output logic [IDX_W-1:0] slot_o
);

    localparam logic [IDX_W-1:0] PART = IDX_W'(NODES_IN_PARTITION);

    // Node n lives in thread n / partition, slot n % partition.
    always_comb begin
        thread_o = node_i / PART;
        slot_o   = node_i % PART;
    end

endmodule

// File: rtl/pagerank_graph_loader.sv
// Stream-fed writer for the pagerank engine graph arrays; arms the engine
// once the whole graph has been loaded and waits for it to complete.
module pagerank_graph_loader
    import pagerank_pkg::*;
#(
    parameter int NUM_HW_THREADS     = NUM_HW_THREADS_DEF,
    parameter int NODES_IN_PARTITION = NODES_IN_PARTITION_DEF,
    parameter int NODES_IN_GRAPH     = NODES_IN_GRAPH_DEF,
    parameter int STREAM_SIZE        = STREAM_SIZE_DEF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    output logic [31:0] source_id  [NUM_HW_THREADS][NODES_IN_PARTITION],
    output logic [31:0] out_degree [NUM_HW_THREADS][NODES_IN_PARTITION],
    output logic [31:0] dest_id    [NUM_HW_THREADS][NODES_IN_PARTITION][STREAM_SIZE],
    output logic        pagerank_enable,
    input  logic        pagerank_complete,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  error_code
);

    // Node index must be able to represent NODES_IN_GRAPH itself so the
    // partition divisor never truncates; edge index must hold STREAM_SIZE.
    localparam int IDX_W  = $clog2(NODES_IN_GRAPH + 1);
    localparam int EDGE_W = $clog2(STREAM_SIZE + 1);

    localparam logic [IDX_W-1:0] LAST_NODE = IDX_W'(NODES_IN_GRAPH - 1);
    localparam logic [31:0]      MAX_DEG   = 32'(STREAM_SIZE);
    localparam logic [31:0]      NUM_NODES = 32'(NODES_IN_GRAPH);

    loader_state_t     state_q, state_d;
    logic [IDX_W-1:0]  node_q, node_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic [EDGE_W-1:0] deg_q, deg_d;
    logic              enable_q, enable_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              in_ready_q, busy_q, done_q, error_q;

    logic              accept_s;
    logic              clr_s, hdr_wr_s, dst_wr_s;
    logic              hdr_last_s, dst_last_edge_s, dst_last_s;
    logic [IDX_W-1:0]  thread_s, slot_s;
    logic [31:0]       node_ext_s;

    pagerank_slot_index #(
        .NODES_IN_PARTITION (NODES_IN_PARTITION),
        .IDX_W              (IDX_W)
    ) u_slot_index (
        .node_i   (node_q),
        .thread_o (thread_s),
        .slot_o   (slot_s)
    );

    assign accept_s        = in_valid && in_ready_q;
    assign node_ext_s      = {{(32-IDX_W){1'b0}}, node_q};
    // in_last belongs on the final word of the final node only.
    assign hdr_last_s      = (in_data == 32'd0) && (node_q == LAST_NODE);
    assign dst_last_edge_s = ((edge_q + EDGE_W'(1)) == deg_q);
    assign dst_last_s      = dst_last_edge_s && (node_q == LAST_NODE);

    // Next-state and array write-enable decode for the load/run sequence.
    always_comb begin
        state_d    = state_q;
        node_d     = node_q;
        edge_d     = edge_q;
        deg_d      = deg_q;
        enable_d   = enable_q;
        err_code_d = err_code_q;
        clr_s      = 1'b0;
        hdr_wr_s   = 1'b0;
        dst_wr_s   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    clr_s      = 1'b1;
                    state_d    = ST_HEADER;
                    node_d     = '0;
                    edge_d     = '0;
                    deg_d      = '0;
                    enable_d   = 1'b0;
                    err_code_d = ERR_NONE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_HEADER: begin
                if (!accept_s) begin
                    state_d = ST_HEADER;
                end else if (in_data > MAX_DEG) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_DEGREE;
                end else if (in_last != hdr_last_s) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_LAST;
                end else begin
                    hdr_wr_s = 1'b1;
                    edge_d   = '0;
                    deg_d    = in_data[EDGE_W-1:0];
                    if (in_data != 32'd0) begin
                        state_d = ST_DEST;
                    end else if (node_q == LAST_NODE) begin
                        state_d = ST_ARM;
                    end else begin
                        node_d  = node_q + IDX_W'(1);
                        state_d = ST_HEADER;
                    end
                end
            end
            ST_DEST: begin
                if (!accept_s) begin
                    state_d = ST_DEST;
                end else if (in_data >= NUM_NODES) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_DEST;
                end else if (in_last != dst_last_s) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_LAST;
                end else begin
                    dst_wr_s = 1'b1;
                    if (!dst_last_edge_s) begin
                        edge_d = edge_q + EDGE_W'(1);
                    end else if (node_q == LAST_NODE) begin
                        edge_d  = '0;
                        state_d = ST_ARM;
                    end else begin
                        edge_d  = '0;
                        node_d  = node_q + IDX_W'(1);
                        state_d = ST_HEADER;
                    end
                end
            end
            ST_ARM: begin
                enable_d = 1'b1;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                if (pagerank_complete) begin
                    enable_d = 1'b0;
                    state_d  = ST_DONE;
                end else begin
                    enable_d = 1'b1;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d    = ST_IDLE;
                enable_d   = 1'b0;
                err_code_d = ERR_NONE;
            end
        endcase
    end

    // Control registers; status outputs are registered from the next state.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            node_q     <= '0;
            edge_q     <= '0;
            deg_q      <= '0;
            enable_q   <= 1'b0;
            err_code_q <= ERR_NONE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            node_q     <= node_d;
            edge_q     <= edge_d;
            deg_q      <= deg_d;
            enable_q   <= enable_d;
            err_code_q <= err_code_d;
            in_ready_q <= (state_d == ST_HEADER) || (state_d == ST_DEST);
            busy_q     <= (state_d != ST_IDLE) && (state_d != ST_DONE) && (state_d != ST_ERROR);
            done_q     <= (state_d == ST_DONE);
            error_q    <= (state_d == ST_ERROR);
        end
    end

    // Graph array storage: cleared on reset or a new load, one slot written per accepted word.
    always_ff @(posedge clock) begin
        for (int t = 0; t < NUM_HW_THREADS; t++) begin
            for (int s = 0; s < NODES_IN_PARTITION; s++) begin
                if (!reset_n || clr_s) begin
                    source_id[t][s]  <= 32'd0;
                    out_degree[t][s] <= 32'd0;
                    for (int e = 0; e < STREAM_SIZE; e++) begin
                        dest_id[t][s][e] <= 32'd0;
                    end
                end else if (hdr_wr_s && (t[IDX_W-1:0] == thread_s) && (s[IDX_W-1:0] == slot_s)) begin
                    source_id[t][s]  <= node_ext_s;
                    out_degree[t][s] <= in_data;
                end else if (dst_wr_s && (t[IDX_W-1:0] == thread_s) && (s[IDX_W-1:0] == slot_s)) begin
                    for (int e = 0; e < STREAM_SIZE; e++) begin
                        if (e[EDGE_W-1:0] == edge_q) begin
                            dest_id[t][s][e] <= in_data;
                        end
                    end
                end
            end
        end
    end

    assign in_ready        = in_ready_q;
    assign pagerank_enable = enable_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;
    assign error_code      = err_code_q;

endmodule

// File: tb/tb_pagerank_graph_loader.sv
// Directed, table-driven bench for pagerank_graph_loader (default geometry).
module tb_pagerank_graph_loader;

    typedef struct {
        logic [31:0] deg;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] d3;
    } node_exp_t;

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic        last;
        logic [1:0]  code;
    } err_vec_t;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [31:0] source_id  [11][1];
    logic [31:0] out_degree [11][1];
    logic [31:0] dest_id    [11][1][4];
    logic        pagerank_enable;
    logic        pagerank_complete;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  error_code;

    logic [31:0] words [29];
    node_exp_t   exp_nodes [11];
    err_vec_t    err_vecs [5];

    int total_checks = 0;
    int pass_checks  = 0;

    pagerank_graph_loader dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .start             (start),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_last           (in_last),
        .source_id         (source_id),
        .out_degree        (out_degree),
        .dest_id           (dest_id),
        .pagerank_enable   (pagerank_enable),
        .pagerank_complete (pagerank_complete),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .error_code        (error_code)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) pass_checks++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // Sends words[0 .. stop_after-1]; word bad_idx is replaced by bad_data/bad_last.
    task automatic send_stream(input bit rnd, input int stop_after, input int bad_idx,
                               input logic [31:0] bad_data, input logic bad_last,
                               output int cycles);
        int  idx;
        int  budget;
        bit  go;
        idx    = 0;
        budget = 0;
        cycles = 0;
        while (idx < stop_after && budget < 400) begin
            @(negedge clock);
            if (rnd && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 32'hDEAD_BEEF;
                in_last  = 1'b1;
            end else begin
                in_valid = 1'b1;
                in_data  = (idx == bad_idx) ? bad_data : words[idx];
                in_last  = (idx == bad_idx) ? bad_last : (idx == 28);
            end
            go = in_valid && in_ready;
            @(posedge clock);
            cycles++;
            budget++;
            if (go) idx++;
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 32'd0;
        if (idx < stop_after) check("stream_timeout_words", 32'(idx), 32'(stop_after));
    endtask

    // Called right after the final word's accepting edge.
    task automatic run_engine(input string tag);
        @(negedge clock);
        check({tag, "_arm_enable_low"}, 32'(pagerank_enable), 32'd0);
        check({tag, "_arm_busy"}, 32'(busy), 32'd1);
        @(negedge clock);
        check({tag, "_run_enable_high"}, 32'(pagerank_enable), 32'd1);
        repeat (6) @(negedge clock);
        check({tag, "_run_enable_hold"}, 32'(pagerank_enable), 32'd1);
        check({tag, "_run_not_done"}, 32'(done), 32'd0);
        pagerank_complete = 1'b1;
        @(posedge clock);
        #1 pagerank_complete = 1'b0;
        @(negedge clock);
        check({tag, "_done_enable_drop"}, 32'(pagerank_enable), 32'd0);
        check({tag, "_done_level"}, 32'(done), 32'd1);
        check({tag, "_done_not_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic check_arrays(input string tag);
        for (int k = 0; k < 11; k++) begin
            check($sformatf("%s_src%0d", tag, k), source_id[k][0], 32'(k));
            check($sformatf("%s_deg%0d", tag, k), out_degree[k][0], exp_nodes[k].deg);
            check($sformatf("%s_dst%0d_0", tag, k), dest_id[k][0][0], exp_nodes[k].d0);
            check($sformatf("%s_dst%0d_1", tag, k), dest_id[k][0][1], exp_nodes[k].d1);
            check($sformatf("%s_dst%0d_2", tag, k), dest_id[k][0][2], exp_nodes[k].d2);
            check($sformatf("%s_dst%0d_3", tag, k), dest_id[k][0][3], exp_nodes[k].d3);
        end
    endtask

    initial begin
        int cyc;

        words = '{32'd4, 32'd2, 32'd3, 32'd4, 32'd5,
                  32'd4, 32'd2, 32'd3, 32'd6, 32'd7,
                  32'd1, 32'd10,
                  32'd1, 32'd9,
                  32'd2, 32'd8, 32'd9,
                  32'd2, 32'd8, 32'd10,
                  32'd2, 32'd8, 32'd9,
                  32'd2, 32'd8, 32'd10,
                  32'd0, 32'd0, 32'd0};
        exp_nodes[0]  = '{32'd4, 32'd2,  32'd3, 32'd4, 32'd5};
        exp_nodes[1]  = '{32'd4, 32'd2,  32'd3, 32'd6, 32'd7};
        exp_nodes[2]  = '{32'd1, 32'd10, 32'd0, 32'd0, 32'd0};
        exp_nodes[3]  = '{32'd1, 32'd9,  32'd0, 32'd0, 32'd0};
        exp_nodes[4]  = '{32'd2, 32'd8,  32'd9, 32'd0, 32'd0};
        exp_nodes[5]  = '{32'd2, 32'd8,  32'd10, 32'd0, 32'd0};
        exp_nodes[6]  = '{32'd2, 32'd8,  32'd9, 32'd0, 32'd0};
        exp_nodes[7]  = '{32'd2, 32'd8,  32'd10, 32'd0, 32'd0};
        exp_nodes[8]  = '{32'd0, 32'd0,  32'd0, 32'd0, 32'd0};
        exp_nodes[9]  = '{32'd0, 32'd0,  32'd0, 32'd0, 32'd0};
        exp_nodes[10] = '{32'd0, 32'd0,  32'd0, 32'd0, 32'd0};
        err_vecs[0] = '{0,  32'd5,  1'b0, 2'd1};
        err_vecs[1] = '{15, 32'd11, 1'b0, 2'd2};
        err_vecs[2] = '{9,  32'd7,  1'b1, 2'd3};
        err_vecs[3] = '{28, 32'd0,  1'b0, 2'd3};
        err_vecs[4] = '{0,  32'd5,  1'b1, 2'd1};

        reset_n           = 1'b0;
        start             = 1'b0;
        in_data           = 32'd0;
        in_valid          = 1'b0;
        in_last           = 1'b0;
        pagerank_complete = 1'b0;

        // Reset state.
        do_reset();
        @(negedge clock);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_error_code", 32'(error_code), 32'd0);
        check("rst_enable", 32'(pagerank_enable), 32'd0);
        check("rst_src5", source_id[5][0], 32'd0);

        // Valid words in IDLE are ignored.
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = 32'd9;
        in_last  = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_in_ready", 32'(in_ready), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_error", 32'(error), 32'd0);
        check("idle_deg0", out_degree[0][0], 32'd0);
        in_valid = 1'b0;
        in_last  = 1'b0;

        // Full load with continuous valid.
        pulse_start();
        check("start_busy", 32'(busy), 32'd1);
        check("start_in_ready", 32'(in_ready), 32'd1);
        send_stream(1'b0, 29, -1, 32'd0, 1'b0, cyc);
        check("load_cycles", 32'(cyc), 32'd29);
        run_engine("load1");
        check_arrays("load1");

        // Start from DONE clears arrays, then reload with gapped valid.
        pulse_start();
        check("restart_done_clear", 32'(done), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_deg0", out_degree[0][0], 32'd0);
        check("restart_dst1_3", dest_id[1][0][3], 32'd0);
        check("restart_src10", source_id[10][0], 32'd0);
        send_stream(1'b1, 29, -1, 32'd0, 1'b0, cyc);
        run_engine("load2");
        check_arrays("load2");

        // Error vectors: one faulty word, then sticky ERROR.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            pulse_start();
            send_stream(1'b0, err_vecs[v].idx + 1, err_vecs[v].idx,
                        err_vecs[v].data, err_vecs[v].last, cyc);
            @(negedge clock);
            check($sformatf("err%0d_error", v), 32'(error), 32'd1);
            check($sformatf("err%0d_code", v), 32'(error_code), 32'(err_vecs[v].code));
            check($sformatf("err%0d_in_ready", v), 32'(in_ready), 32'd0);
            check($sformatf("err%0d_enable", v), 32'(pagerank_enable), 32'd0);
            check($sformatf("err%0d_busy", v), 32'(busy), 32'd0);
            pulse_start();
            repeat (3) @(negedge clock);
            check($sformatf("err%0d_sticky", v), 32'(error), 32'd1);
            check($sformatf("err%0d_sticky_enable", v), 32'(pagerank_enable), 32'd0);
        end

        // Reset during DEST, then a clean load.
        do_reset();
        pulse_start();
        send_stream(1'b0, 3, -1, 32'd0, 1'b0, cyc);
        @(negedge clock);
        check("mid_pre_deg0", out_degree[0][0], 32'd4);
        reset_n = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_error", 32'(error), 32'd0);
        check("mid_rst_deg0", out_degree[0][0], 32'd0);
        check("mid_rst_dst0_1", dest_id[0][0][1], 32'd0);
        pulse_start();
        check("mid_start_busy", 32'(busy), 32'd1);
        send_stream(1'b0, 29, -1, 32'd0, 1'b0, cyc);
        run_engine("load3");
        check_arrays("load3");

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
